ysyx_25060170_seq: RTL and testbench
====================================

Name: ysyx_25060170_seq

Overview:
Multi-cycle core sequencer FSM for the NPC datapath.
- Steps each instruction through fetch → execute → optional memory access → writeback.
- Issues request/acknowledge handshakes to the IFU and the data-memory port.
- Gates the WBU register-write enable and the PC update so each happens exactly once per retired instruction.
- Detects halt (ebreak), illegal instructions and memory timeouts, and keeps a retired-instruction counter.

Parameters:
- ICNT_W, 32, width of the retired-instruction counter.
- TIMEOUT, 255, maximum cycles spent waiting for ifu_ack_i or lsu_ack_i before error (≥2); wait counter width = $clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset: synchronous, active-low.
- ifu_req_o  out  1  instruction fetch request.
- ifu_ack_i  in  1  fetch data valid.
- ir_we_o  out  1  instruction register latch strobe.
- is_load_i  in  1  decoded load; sampled in EXEC.
- is_store_i  in  1  decoded store; sampled in EXEC.
- is_ebreak_i  in  1  decoded ebreak; sampled in EXEC.
- illegal_i  in  1  decode illegal flag; sampled in EXEC.
- lsu_req_o  out  1  data memory request.
- lsu_wen_o  out  1  data memory write (store) qualifier.
- lsu_ack_i  in  1  data memory done.
- wb_en_o  out  1  writeback strobe; ANDed with RegW at the WBU.
- pc_we_o  out  1  PC update strobe.
- halt_o  out  1  ebreak reached.
- err_o  out  1  error state reached.
- err_code_o  out  2  0 none, 1 fetch timeout, 2 LSU timeout, 3 illegal.
- instret_o  out  ICNT_W  retired-instruction count.
- state_o  out  3  current state encoding.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE.
  - All strobes 0; halt_o, err_o, err_code_o, instret_o = 0.
  - Reset mid-operation aborts any pending handshake; outstanding acks are then ignored.
- State encoding: IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6; 7 is unreachable and maps to ERR with err_code 3.
- IDLE: one cycle, then FETCH.
- FETCH:
  - ifu_req_o=1 combinationally while in state.
  - If ifu_ack_i=1: ir_we_o=1 in the same cycle; next state EXEC.
  - Otherwise wait counter increments. If the counter reaches TIMEOUT-1 with no ack: next state ERR, err_code=1.
  - An ack on the timeout cycle wins (no error).
- EXEC: one cycle; priority order:
  1. illegal_i, or is_load_i & is_store_i → ERR, code 3.
  2. is_ebreak_i → HALT.
  3. is_load_i | is_store_i → MEM; latch is_store_i into the lsu_wen register.
  4. Otherwise → WB.
- MEM:
  - lsu_req_o=1 and lsu_wen_o=latched store flag, both held until ack.
  - On lsu_ack_i → WB.
  - Timeout rule as in FETCH, with err_code=2.
- Wait counter: cleared on entry to FETCH and to MEM. A single-cycle ack gives zero stall.
- WB:
  - wb_en_o=1 and pc_we_o=1 for exactly one cycle.
  - instret_o increments by 1 at the clock edge; wraps modulo 2^ICNT_W.
  - Next state FETCH.
- HALT: halt_o=1. Absorbing until reset; all request/strobe outputs 0; instret frozen. The ebreak itself is not counted.
- ERR: err_o=1, err_code_o held. Absorbing until reset; all strobes 0.
- Acks arriving in any state other than their wait state are ignored.
- Minimum latency: ALU instruction 3 cycles (FETCH, EXEC, WB); load/store 4 cycles.
- halt_o, err_o, err_code_o and instret_o are registered; request/strobe outputs are Moore/Mealy as stated above.

Test Plan:
- Reset, then ifu_ack_i tied 1, ALU-only decode → state sequence 0,1,2,4,1,2,4…; wb_en_o/pc_we_o pulse every 3rd cycle; instret_o=10 after 30 cycles post-IDLE.
- Load with lsu_ack_i delayed 5 cycles → lsu_req_o high 6 cycles; lsu_wen_o=0; single wb_en_o pulse after ack. Store → lsu_wen_o=1 throughout MEM.
- ifu_ack_i never asserted → err_o=1 and err_code_o=1 after exactly TIMEOUT FETCH cycles. Repeat with ack on the last allowed cycle → no error; EXEC entered.
- EXEC with illegal_i=1 and is_ebreak_i=1 → ERR, code 3. With ebreak only → halt_o=1, instret unchanged, ifu_req_o stays 0 for 20 further cycles.
- Reset asserted mid-MEM with lsu_ack_i arriving the next cycle → IDLE, no wb_en_o/pc_we_o, instret_o=0.
- ICNT_W=4, 16 ALU instructions → instret_o wraps to 0.

Source files
------------

// File: rtl/ysyx_25060170_seq.sv
// Multi-cycle sequencer for the NPC core: fetch -> exec -> (mem) -> writeback.
// Drives the IFU/LSU handshakes, gates register writeback and PC update to
// once per retired instruction, and flags halt, illegal opcodes and timeouts.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | post-reset settle cycle
// FETCH | ifu_req_o high, waiting for ifu_ack_i (bounded by TIMEOUT)
// EXEC  | decode flags sampled, route to MEM / WB / HALT / ERR
// MEM   | lsu_req_o high, waiting for lsu_ack_i (bounded by TIMEOUT)
// WB    | single-cycle writeback + PC update, instret bump
// HALT  | ebreak retired; absorbing until reset
// ERR   | timeout or illegal instruction; absorbing until reset
// (7)   | unreachable; recovers into ERR with the illegal code
module ysyx_25060170_seq #(
   parameter int ICNT_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ifu_req_o,
   input  logic              ifu_ack_i,
   output logic              ir_we_o,
   input  logic              is_load_i,
   input  logic              is_store_i,
   input  logic              is_ebreak_i,
   input  logic              illegal_i,
   output logic              lsu_req_o,
   output logic              lsu_wen_o,
   input  logic              lsu_ack_i,
   output logic              wb_en_o,
   output logic              pc_we_o,
   output logic              halt_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   output logic [ICNT_W-1:0] instret_o,
   output logic [2:0]        state_o
);

   localparam int WCNT_W = $clog2(TIMEOUT + 1);
   // Last wait cycle on which an ack is still accepted.
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_FETCH   = 2'd1;
   localparam logic [1:0] ERR_LSU     = 2'd2;
   localparam logic [1:0] ERR_ILLEGAL = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4,
      S_HALT  = 3'd5,
      S_ERR   = 3'd6,
      S_BAD   = 3'd7
   } state_t;

   state_t              state;
   logic [WCNT_W-1:0]   wait_cnt;
   logic                wen_q;
   logic                halt_q;
   logic                err_q;
   logic [1:0]          err_code_q;
   logic [ICNT_W-1:0]   instret_q;

   // Sequencer state, wait timer, store latch and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         wen_q      <= 1'b0;
         halt_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         instret_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               wait_cnt <= '0;
               state    <= S_FETCH;
            end
            S_FETCH: begin
               // An ack on the final allowed cycle still wins over the timeout.
               if (ifu_ack_i) begin
                  state <= S_EXEC;
               end else if (wait_cnt == WAIT_LAST) begin
                  state      <= S_ERR;
                  err_q      <= 1'b1;
                  err_code_q <= ERR_FETCH;
               end else begin
                  wait_cnt <= wait_cnt + WCNT_W'(1);
               end
            end
            S_EXEC: begin
               if (illegal_i || (is_load_i && is_store_i)) begin
                  state      <= S_ERR;
                  err_q      <= 1'b1;
                  err_code_q <= ERR_ILLEGAL;
               end else if (is_ebreak_i) begin
                  state  <= S_HALT;
                  halt_q <= 1'b1;
               end else if (is_load_i || is_store_i) begin
                  state    <= S_MEM;
                  wen_q    <= is_store_i;
                  wait_cnt <= '0;
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (lsu_ack_i) begin
                  state <= S_WB;
               end else if (wait_cnt == WAIT_LAST) begin
                  state      <= S_ERR;
                  err_q      <= 1'b1;
                  err_code_q <= ERR_LSU;
               end else begin
                  wait_cnt <= wait_cnt + WCNT_W'(1);
               end
            end
            S_WB: begin
               instret_q <= instret_q + ICNT_W'(1);
               wait_cnt  <= '0;
               state     <= S_FETCH;
            end
            S_HALT: state <= S_HALT;
            S_ERR:  state <= S_ERR;
            default: begin
               state      <= S_ERR;
               err_q      <= 1'b1;
               err_code_q <= ERR_ILLEGAL;
            end
         endcase
      end
   end

   // Handshake and strobe outputs decoded from the current state.
   always_comb begin
      ifu_req_o = (state == S_FETCH);
      ir_we_o   = (state == S_FETCH) && ifu_ack_i;
      lsu_req_o = (state == S_MEM);
      lsu_wen_o = (state == S_MEM) && wen_q;
      wb_en_o   = (state == S_WB);
      pc_we_o   = (state == S_WB);
   end

   assign halt_o     = halt_q;
   assign err_o      = err_q;
   assign err_code_o = err_code_q;
   assign instret_o  = instret_q;
   assign state_o    = state;

endmodule

// File: tb/tb_ysyx_25060170_seq.sv
// Directed bench for the core sequencer. Expected retired counts are queued
// when an instruction is launched and checked against each writeback pulse.
module tb_ysyx_25060170_seq;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_ack, is_load, is_store, is_ebreak, illegal, lsu_ack;

   logic        ifu_req, ir_we, lsu_req, lsu_wen, wb_en, pc_we, halt, err;
   logic [1:0]  err_code;
   logic [31:0] instret;
   logic [2:0]  state;

   logic        d4_ifu_req, d4_ir_we, d4_lsu_req, d4_lsu_wen, d4_wb_en, d4_pc_we, d4_halt, d4_err;
   logic [1:0]  d4_err_code;
   logic [3:0]  d4_instret;
   logic [2:0]  d4_state;

   int          tests = 0;
   int          fails = 0;
   int unsigned exp_q[$];
   logic [2:0]  alu_seq [3] = '{3'd1, 3'd2, 3'd4};

   always #5 clk = ~clk;

   ysyx_25060170_seq #(.ICNT_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_o(ifu_req), .ifu_ack_i(ifu_ack), .ir_we_o(ir_we),
      .is_load_i(is_load), .is_store_i(is_store), .is_ebreak_i(is_ebreak), .illegal_i(illegal),
      .lsu_req_o(lsu_req), .lsu_wen_o(lsu_wen), .lsu_ack_i(lsu_ack),
      .wb_en_o(wb_en), .pc_we_o(pc_we), .halt_o(halt), .err_o(err),
      .err_code_o(err_code), .instret_o(instret), .state_o(state)
   );

   ysyx_25060170_seq #(.ICNT_W(4), .TIMEOUT(TMO)) dut4 (
      .clk(clk), .rst(rst),
      .ifu_req_o(d4_ifu_req), .ifu_ack_i(ifu_ack), .ir_we_o(d4_ir_we),
      .is_load_i(is_load), .is_store_i(is_store), .is_ebreak_i(is_ebreak), .illegal_i(illegal),
      .lsu_req_o(d4_lsu_req), .lsu_wen_o(d4_lsu_wen), .lsu_ack_i(lsu_ack),
      .wb_en_o(d4_wb_en), .pc_we_o(d4_pc_we), .halt_o(d4_halt), .err_o(d4_err),
      .err_code_o(d4_err_code), .instret_o(d4_instret), .state_o(d4_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      rst = 1'b0;
      ifu_ack = 1'b0; is_load = 1'b0; is_store = 1'b0;
      is_ebreak = 1'b0; illegal = 1'b0; lsu_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ctl", 32'({ifu_req, ir_we, lsu_req, lsu_wen, wb_en, pc_we, halt, err, err_code, state}), 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_ctl4", 32'({d4_ifu_req, d4_ir_we, d4_lsu_req, d4_lsu_wen, d4_wb_en, d4_pc_we,
                           d4_halt, d4_err, d4_err_code, d4_state}), 32'd0);
      chk("rst_instret4", 32'(d4_instret), 32'd0);
      rst = 1'b1;
   endtask

   // Scoreboard side: every writeback pulse must match a queued expectation.
   always @(negedge clk) begin
      if (wb_en) begin
         chk("wb_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            automatic int unsigned e = exp_q.pop_front();
            chk("wb_instret", instret, e);
            chk("wb_instret4", 32'(d4_instret), e & 32'hF);
            chk("wb_pc_we", 32'(pc_we), 32'd1);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bit done;
      rst = 1'b0;
      ifu_ack = 1'b0; is_load = 1'b0; is_store = 1'b0;
      is_ebreak = 1'b0; illegal = 1'b0; lsu_ack = 1'b0;

      // ALU stream with fetch always ready: FETCH, EXEC, WB repeating.
      do_reset();
      ifu_ack = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back(i);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk("alu_state", 32'(state), 32'(alu_seq[i % 3]));
         chk("alu_wb", 32'(wb_en), 32'(i % 3 == 2));
         chk("alu_ir_we", 32'(ir_we), 32'(i % 3 == 0));
      end
      @(negedge clk);
      chk("alu_instret10", instret, 32'd10);

      // Load with ack on the sixth MEM cycle, then a store with ack on the third.
      do_reset();
      ifu_ack = 1'b1; is_load = 1'b1;
      @(negedge clk); chk("ld_fetch", 32'(state), 32'd1);
      @(negedge clk); chk("ld_exec", 32'(state), 32'd2);
      ifu_ack = 1'b0;
      exp_q.push_back(0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("ld_req", 32'(lsu_req), 32'd1);
         chk("ld_wen", 32'(lsu_wen), 32'd0);
         if (k == 5) lsu_ack = 1'b1;
      end
      @(negedge clk);
      chk("ld_wb_state", 32'(state), 32'd4);
      chk("ld_req_drop", 32'(lsu_req), 32'd0);
      lsu_ack = 1'b0; is_load = 1'b0;
      @(negedge clk);
      chk("ld_instret", instret, 32'd1);
      chk("ld_refetch", 32'(state), 32'd1);
      is_store = 1'b1; ifu_ack = 1'b1;
      @(negedge clk); chk("st_exec", 32'(state), 32'd2);
      ifu_ack = 1'b0;
      exp_q.push_back(1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("st_req", 32'(lsu_req), 32'd1);
         chk("st_wen", 32'(lsu_wen), 32'd1);
         if (k == 2) lsu_ack = 1'b1;
      end
      @(negedge clk);
      chk("st_wb_state", 32'(state), 32'd4);
      lsu_ack = 1'b0; is_store = 1'b0;
      @(negedge clk);
      chk("st_instret", instret, 32'd2);
      chk("st_wen_drop", 32'(lsu_wen), 32'd0);

      // Fetch never acknowledged: error after exactly TMO fetch cycles.
      do_reset();
      n = 0; done = 1'b0;
      for (int k = 0; k < 2 * TMO && !done; k++) begin
         @(negedge clk);
         if (err) done = 1'b1;
         else if (ifu_req) n++;
      end
      chk("tmo_seen", 32'(done), 32'd1);
      chk("tmo_cycles", n, TMO);
      chk("tmo_code", 32'(err_code), 32'd1);
      chk("tmo_state", 32'(state), 32'd6);
      ifu_ack = 1'b1; lsu_ack = 1'b1;
      repeat (5) @(negedge clk);
      chk("err_hold_state", 32'(state), 32'd6);
      chk("err_hold_strobes", 32'({ifu_req, ir_we, lsu_req, wb_en, pc_we}), 32'd0);
      chk("err_hold_code", 32'(err_code), 32'd1);

      // Ack on the last allowed fetch cycle is accepted.
      do_reset();
      for (int k = 0; k < TMO; k++) begin
         @(negedge clk);
         if (k == TMO - 1) begin
            chk("late_fetch", 32'(state), 32'd1);
            ifu_ack = 1'b1;
         end
      end
      @(negedge clk);
      chk("late_exec", 32'(state), 32'd2);
      chk("late_no_err", 32'(err), 32'd0);
      ifu_ack = 1'b0;
      exp_q.push_back(0);
      repeat (2) @(negedge clk);
      chk("late_instret", instret, 32'd1);

      // Illegal has priority over ebreak.
      do_reset();
      ifu_ack = 1'b1; illegal = 1'b1; is_ebreak = 1'b1;
      repeat (2) @(negedge clk);
      ifu_ack = 1'b0;
      @(negedge clk);
      chk("ill_err", 32'({err, halt}), 32'b10);
      chk("ill_code", 32'(err_code), 32'd3);
      chk("ill_state", 32'(state), 32'd6);

      // Simultaneous load and store decode is illegal.
      do_reset();
      ifu_ack = 1'b1; is_load = 1'b1; is_store = 1'b1;
      repeat (2) @(negedge clk);
      ifu_ack = 1'b0;
      @(negedge clk);
      chk("ldst_code", 32'(err_code), 32'd3);
      chk("ldst_no_req", 32'(lsu_req), 32'd0);

      // One ALU instruction, then ebreak: halt with count frozen at 1.
      do_reset();
      ifu_ack = 1'b1;
      exp_q.push_back(0);
      repeat (3) @(negedge clk);
      @(negedge clk);
      chk("eb_pre_count", instret, 32'd1);
      is_ebreak = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("eb_halt", 32'({halt, err}), 32'b10);
      chk("eb_state", 32'(state), 32'd5);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ifu_req || ir_we || lsu_req || wb_en || pc_we) n++;
      end
      chk("eb_quiet", n, 0);
      chk("eb_instret", instret, 32'd1);
      chk("eb_halt_hold", 32'(halt), 32'd1);

      // Reset mid-MEM; the late ack must be ignored.
      do_reset();
      ifu_ack = 1'b1; is_load = 1'b1;
      @(negedge clk);
      @(negedge clk); ifu_ack = 1'b0;
      @(negedge clk); chk("mr_mem", 32'(lsu_req), 32'd1);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("mr_idle", 32'(state), 32'd0);
      chk("mr_req_drop", 32'(lsu_req), 32'd0);
      rst = 1'b1; lsu_ack = 1'b1; is_load = 1'b0;
      @(negedge clk);
      chk("mr_fetch", 32'(state), 32'd1);
      lsu_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("mr_still_fetch", 32'(state), 32'd1);
      chk("mr_instret", instret, 32'd0);

      // Sixteen ALU instructions wrap the 4-bit counter.
      do_reset();
      ifu_ack = 1'b1;
      for (int i = 0; i < 16; i++) exp_q.push_back(i);
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         chk("wrap_state4", 32'(d4_state), 32'(alu_seq[i % 3]));
      end
      @(negedge clk);
      chk("wrap_instret4", 32'(d4_instret), 32'd0);
      chk("wrap_instret32", instret, 32'd16);

      do_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
